tag_release_queue: RTL
======================

Name: tag_release_queue

Overview:
Sits between the retire stage and the physical-tag free list. It is the producer side of the free list's single-tag write port. Retire hands back up to two freed physical tags per cycle. This block buffers them in a circular queue and drains them one per cycle into the free list's write_tag/write_tag_source port. It filters null tags and flags overflow.

Parameters:
DEPTH, 16, queue entries; power of two, minimum 4
TAG_W, 8, physical tag width; matches the free list data width
NO_TAG, 8'hFF, reserved "no old mapping" value; never enqueued

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-low reset (asserted when 0)
release_valid_0  in  1  retire slot 0 frees a tag this cycle
release_tag_0  in  TAG_W  tag freed by slot 0
release_valid_1  in  1  retire slot 1 frees a tag this cycle
release_tag_1  in  TAG_W  tag freed by slot 1
release_ready  out  1  queue can accept two tags this cycle
drain_enable  in  1  free list may take a tag this cycle; low stalls draining
write_tag  out  1  registered strobe to the free list write port
write_tag_source  out  TAG_W  registered tag to the free list
pending_count  out  $clog2(DEPTH+1)  entries currently queued, excluding the output register
overflow  out  1  sticky: a push was dropped for lack of space

Behaviour:
- Reset (reset==0, asynchronous) sets:
  - head, tail and count to 0
  - write_tag=0, write_tag_source=0, overflow=0
  - Queue RAM contents are don't-care.
- Reset asserted mid-operation discards all queued tags; nothing is emitted after release.
- release_ready = (DEPTH - count) >= 2. Purely combinational from count; it does not depend on this cycle's pops.
- Push filtering: a slot counts only if valid==1 and tag != NO_TAG.
- Push compaction:
  - Both slots count: slot 0 is written at tail, slot 1 at tail+1, tail += 2.
  - Only one slot counts (either slot): it is written at tail, tail += 1.
- Pointer wrap: head and tail wrap modulo DEPTH. With power-of-two DEPTH this is natural truncation; no special case at DEPTH-1.
- Overflow:
  - Pushes are evaluated against free space = DEPTH - count at the start of the cycle.
  - If free space < 1 and any push counts, all pushes that cycle are dropped.
  - If free space == 1 and two pushes count, slot 0 is kept, slot 1 is dropped.
  - Any dropped push sets overflow; it stays set until reset.
  - Pushes while release_ready==0 are legal but may drop.
- Drain:
  - On each posedge, if count>0 and drain_enable==1: write_tag<=1, write_tag_source<=queue[head], head+=1.
  - Otherwise write_tag<=0 and write_tag_source holds its value.
  - At most one tag is drained per cycle.
- Simultaneous push and pop in the same cycle: count_next = count + pushes - pop.
  - A pop never sees a tag pushed in the same cycle (no bypass).
  - Minimum latency is release in cycle N -> write_tag high in cycle N+2.
- Empty: count==0 gives write_tag=0 next cycle regardless of drain_enable.
- Full: count==DEPTH; release_ready=0; draining continues normally.
- Ordering: tags reach the free list in strict FIFO order. Within a cycle, slot 0 precedes slot 1.
- pending_count = count; updates on the same edge as pointers.
- Assertions (simulation only): count <= DEPTH; no pop when count==0.

Test Plan:
- Reset then idle, drain_enable=1 -> write_tag stays 0, pending_count=0, release_ready=1, overflow=0.
- Push tags 8'h10 (slot 0) and 8'h11 (slot 1) in cycle 0, drain_enable=1 -> write_tag=1 with 8'h10 in cycle 2, 8'h11 in cycle 3, write_tag=0 in cycle 4.
- Push valid_0 with NO_TAG and valid_1 with 8'h22 -> only 8'h22 is queued; pending_count goes to 1 next cycle.
- Push two tags/cycle with drain_enable=0 until full (DEPTH=16: 8 cycles) -> release_ready=0 once count>=15.
  - Then push 2 more -> both dropped, overflow=1, count=16.
  - Then drain_enable=1 -> tags come out in original order, and the wrap of head past entry 15 is correct.
- Steady state with two pushes and one pop per cycle starting at count=14 -> count=15 after one edge, release_ready=0.
  - Next cycle push 2 with free space=1 -> slot 0 kept, slot 1 dropped, overflow=1.
- Queue 5 tags, assert reset low mid-drain -> write_tag=0 and pending_count=0 immediately (asynchronous).
  - After release, no stale tags are emitted.

Source files
------------

// File: rtl/tag_release_queue.sv
// Circular queue between retire and the free list's single-tag write port.
// Takes up to two freed tags per cycle, drops null tags, and drains one tag per cycle.

module tag_release_slot #(
  parameter int              TAG_W  = 8,
  parameter logic [TAG_W-1:0] NO_TAG = TAG_W'(8'hFF)
) (
  input  logic             valid,
  input  logic [TAG_W-1:0] tag,
  output logic             keep
);
  assign keep = valid && (tag != NO_TAG);
endmodule

module tag_release_queue #(
  parameter int               DEPTH  = 16,
  parameter int               TAG_W  = 8,
  parameter logic [TAG_W-1:0] NO_TAG = TAG_W'(8'hFF)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       release_valid_0,
  input  logic [TAG_W-1:0]           release_tag_0,
  input  logic                       release_valid_1,
  input  logic [TAG_W-1:0]           release_tag_1,
  output logic                       release_ready,
  input  logic                       drain_enable,
  output logic                       write_tag,
  output logic [TAG_W-1:0]           write_tag_source,
  output logic [$clog2(DEPTH+1)-1:0] pending_count,
  output logic                       overflow
);
  localparam int NUM_SLOTS = 2;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [NUM_SLOTS-1:0][TAG_W-1:0] rel_tag;
  logic [NUM_SLOTS-1:0]            rel_vld;
  logic [NUM_SLOTS-1:0]            keep;

  assign rel_tag = {release_tag_1, release_tag_0};
  assign rel_vld = {release_valid_1, release_valid_0};

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    tag_release_slot #(.TAG_W(TAG_W), .NO_TAG(NO_TAG)) u_slot (
      .valid (rel_vld[g]),
      .tag   (rel_tag[g]),
      .keep  (keep[g])
    );
  end

  logic [TAG_W-1:0] mem [DEPTH];
  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count, free, count_nxt;

  logic             wr0_en, wr1_en, drop, pop;
  logic [TAG_W-1:0] wr0_tag;
  logic [1:0]       n_acc;

  assign free          = DEPTH_C - count;
  assign release_ready = free >= CW'(2);
  assign pending_count = count;
  assign pop           = (count != '0) && drain_enable;

  // Accepted pushes are compacted so the first kept tag always lands at tail.
  // Space is judged against count at the start of the cycle, ignoring this cycle's pop.
  always_comb begin
    wr0_en  = 1'b0;
    wr1_en  = 1'b0;
    wr0_tag = rel_tag[0];
    drop    = 1'b0;
    n_acc   = 2'd0;
    case (keep)
      2'b11: begin
        if (free >= CW'(2)) begin
          wr0_en = 1'b1;
          wr1_en = 1'b1;
          n_acc  = 2'd2;
        end else if (free == CW'(1)) begin
          wr0_en = 1'b1;
          n_acc  = 2'd1;
          drop   = 1'b1;
        end else begin
          drop   = 1'b1;
        end
      end
      2'b01, 2'b10: begin
        wr0_tag = keep[0] ? rel_tag[0] : rel_tag[1];
        if (free != '0) begin
          wr0_en = 1'b1;
          n_acc  = 2'd1;
        end else begin
          drop   = 1'b1;
        end
      end
      default: ;
    endcase
    count_nxt = count + CW'(n_acc) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (wr0_en) mem[tail]           <= wr0_tag;
    if (wr1_en) mem[tail + PW'(1)]  <= rel_tag[1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      write_tag        <= 1'b0;
      write_tag_source <= '0;
      overflow         <= 1'b0;
    end else begin
      tail      <= tail + PW'(n_acc);
      count     <= count_nxt;
      write_tag <= pop;
      if (pop) begin
        write_tag_source <= mem[head];
        head             <= head + PW'(1);
      end
      if (drop) overflow <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset) begin
      assert (count <= DEPTH_C);
      assert (!(pop && count == '0));
    end
  end
`endif

endmodule
